// File: rtl/joy_db15_if.sv
// Host-side pin bundle of the DB15 joystick adapter shift chain.
// The host (master) drives the strobes and button states; the emulated
// adapter (slave) answers with serial data and status.
interface joy_db15_if #(
  parameter int BITS = 12
);
  logic            joy_clk;
  logic            joy_load;
  logic [BITS-1:0] joystick1;
  logic [BITS-1:0] joystick2;
  logic            joy_data;
  logic            busy;
  logic            frame_strobe;

  modport master (
    output joy_clk,
    output joy_load,
    output joystick1,
    output joystick2,
    input  joy_data,
    input  busy,
    input  frame_strobe
  );

  modport slave (
    input  joy_clk,
    input  joy_load,
    input  joystick1,
    input  joystick2,
    output joy_data,
    output busy,
    output frame_strobe
  );
endinterface

// File: rtl/joy_db15_tx.sv
// Device-side emulator of the DB15 adapter shift chain. Two players' buttons
// are latched (active-low) while the host holds joy_load low, then shifted out
// one bit per host joy_clk rising edge, player 1 bit0 first.
module joy_db15_tx #(
  parameter int BITS        = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  joy_db15_if.slave    bus
);

  localparam int FRAME = 2 * BITS;
  localparam int CNT_W = $clog2(FRAME);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  logic [SYNC_STAGES-1:0] ck_sync_q;
  logic [SYNC_STAGES-1:0] ld_sync_q;
  logic                   ck_prev_q;
  logic                   ld_prev_q;
  logic                   ck_s;
  logic                   ld_s;
  logic                   ck_rise;
  logic                   ld_rise;

  state_t                 state_q, state_d;
  logic [FRAME-1:0]       sreg_q, sreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   data_q, data_d;
  logic                   strobe_q, strobe_d;

  // Bring the asynchronous host strobes into the clk domain; idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      ck_sync_q <= '1;
      ld_sync_q <= '1;
      ck_prev_q <= 1'b1;
      ld_prev_q <= 1'b1;
    end else begin
      ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], bus.joy_clk};
      ld_sync_q <= {ld_sync_q[SYNC_STAGES-2:0], bus.joy_load};
      ck_prev_q <= ck_s;
      ld_prev_q <= ld_s;
    end
  end

  assign ck_s    = ck_sync_q[SYNC_STAGES-1];
  assign ld_s    = ld_sync_q[SYNC_STAGES-1];
  assign ck_rise = ck_s & ~ck_prev_q;
  assign ld_rise = ld_s & ~ld_prev_q;

  // State, shift register, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sreg_q   <= '1;
      cnt_q    <= '0;
      data_q   <= 1'b1;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  // Next-state logic: a low load strobe overrides everything, acting like a
  // transparent parallel load; otherwise edges are interpreted per state.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    strobe_d = 1'b0;

    if (!ld_s) begin
      // Loading from the same cycle the low level is seen keeps the load
      // latency equal to the shift latency (SYNC_STAGES+1 clk cycles).
      state_d = LOAD;
      sreg_d  = {~bus.joystick2, ~bus.joystick1};
      data_d  = ~bus.joystick1[0];
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (ld_rise) begin
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (ck_rise) begin
            sreg_d = {1'b1, sreg_q[FRAME-1:1]};
            if (cnt_q == CNT_W'(FRAME - 1)) begin
              // Last bit consumed: line returns to idle-high, frame reported.
              state_d  = DONE;
              strobe_d = 1'b1;
              data_d   = 1'b1;
            end else begin
              data_d = sreg_q[1];
              cnt_d  = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          // IDLE and DONE: only a new load leaves these states.
          data_d = 1'b1;
        end
      endcase
    end
  end

  assign bus.joy_data     = data_q;
  assign bus.busy         = (state_q == SHIFT);
  assign bus.frame_strobe = strobe_q;

endmodule
